spi_pwm_config_regs: RTL

SPI mode-0 write-only target that owns the PWM configuration register file, driving every configuration input of the PWM output stage.
- Runs entirely in the system clock domain. Oversamples and synchronises the external SPI pins, so SCLK must be well below clk/4.
- Decodes 16-bit frames and commits a register write atomically on chip-select release.
- Emits a one-cycle update pulse on each successful commit and a one-cycle error pulse on each discarded frame.

---
 rtl/spi_pwm_config_regs_if.sv | 10 +
 rtl/spi_pwm_config_regs.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/spi_pwm_config_regs_if.sv
// SPI pad bundle between a bus master and the PWM configuration target.
// The target only listens: write-only, no return data and no backpressure.
interface spi_pwm_config_regs_if;
  logic sclk;
  logic copi;
  logic ncs;

  modport master (output sclk, output copi, output ncs);
  modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_pwm_config_regs.sv
// SPI mode-0 write-only target owning the PWM config registers; commit lands SYNC_STAGES+1 clks
// after ncs is first sampled high. No backpressure: SPI master is free-running, bad frames pulse frame_err.
module spi_pwm_config_regs #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  spi_pwm_config_regs_if.slave    spi,
  output logic [7:0]              reg_en_out,
  output logic [7:0]              reg_en_pwm_out,
  output logic [7:0]              reg_out_3_0_pwm_chanel,
  output logic [7:0]              reg_out_7_4_pwm_chanel,
  output logic [7:0]              reg_pwm_gen_1_duty_cycle,
  output logic [7:0]              reg_pwm_gen_2_duty_cycle,
  output logic [7:0]              reg_pwm_gen_3_duty_cycle,
  output logic [7:0]              reg_pwm_gen_4_duty_cycle,
  output logic [3:0]              reg_pwm_frequency_divider,
  output logic                    cfg_update,
  output logic                    frame_err
);

  localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

  typedef struct packed {
    logic [7:0] en_out;
    logic [7:0] en_pwm;
    logic [7:0] chan_3_0;
    logic [7:0] chan_7_4;
    logic [7:0] duty1;
    logic [7:0] duty2;
    logic [7:0] duty3;
    logic [7:0] duty4;
    logic [3:0] freq_div;
  } cfg_t;

  typedef enum logic {IDLE, SHIFT} state_t;

  cfg_t                   cfg;
  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic                   sclk_hist, ncs_hist;
  logic [15:0]            shift_q, shift_nxt;
  logic [4:0]             cnt_q, cnt_nxt;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_fall, ncs_rise;
  logic                   frame_ok;

  // Idle pad levels: clock low, chip select released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_hist <= 1'b0;
      ncs_hist  <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      ncs_hist  <= ncs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign ncs_fall  = ~ncs_s & ncs_hist;
  assign ncs_rise  = ncs_s & ~ncs_hist;

  // A bit arriving in the same sample as ncs release still belongs to the frame being judged.
  always_comb begin
    shift_nxt = shift_q;
    cnt_nxt   = cnt_q;
    if (sclk_rise) begin
      shift_nxt = {shift_q[14:0], copi_s};
      if (cnt_q != 5'd17) cnt_nxt = cnt_q + 5'd1;
    end
  end

  assign frame_ok = (cnt_nxt == 5'd16) && shift_nxt[15] && (shift_nxt[14:8] <= MAX_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      cfg        <= '0;
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (ncs_fall) begin
            state   <= SHIFT;
            shift_q <= '0;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          shift_q <= shift_nxt;
          cnt_q   <= cnt_nxt;
          if (ncs_rise) begin
            state <= IDLE;
            if (frame_ok) begin
              cfg_update <= 1'b1;
              case (shift_nxt[14:8])
                7'h00:   cfg.en_out   <= shift_nxt[7:0];
                7'h01:   cfg.en_pwm   <= shift_nxt[7:0];
                7'h02:   cfg.chan_3_0 <= shift_nxt[7:0];
                7'h03:   cfg.chan_7_4 <= shift_nxt[7:0];
                7'h04:   cfg.duty1    <= shift_nxt[7:0];
                7'h05:   cfg.duty2    <= shift_nxt[7:0];
                7'h06:   cfg.duty3    <= shift_nxt[7:0];
                7'h07:   cfg.duty4    <= shift_nxt[7:0];
                7'h08:   cfg.freq_div <= shift_nxt[3:0];
                default: ;
              endcase
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign reg_en_out                = cfg.en_out;
  assign reg_en_pwm_out            = cfg.en_pwm;
  assign reg_out_3_0_pwm_chanel    = cfg.chan_3_0;
  assign reg_out_7_4_pwm_chanel    = cfg.chan_7_4;
  assign reg_pwm_gen_1_duty_cycle  = cfg.duty1;
  assign reg_pwm_gen_2_duty_cycle  = cfg.duty2;
  assign reg_pwm_gen_3_duty_cycle  = cfg.duty3;
  assign reg_pwm_gen_4_duty_cycle  = cfg.duty4;
  assign reg_pwm_frequency_divider = cfg.freq_div;

endmodule
